mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter onto one shared Wishbone-style memory bus.
// Ties go round-robin or to the data port, selected by ROUND_ROBIN.
module mem_arbiter #(
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic         clk,
    input  logic         reset,
    // instruction port
    input  logic         i_cyc,
    input  logic         i_stb,
    input  logic [15:0]  i_addr,
    output logic [127:0] i_rdata,
    output logic         i_ack,
    // data port
    input  logic         d_cyc,
    input  logic         d_stb,
    input  logic         d_we,
    input  logic [15:0]  d_addr,
    input  logic [127:0] d_wdata,
    input  logic [15:0]  d_sel,
    output logic [127:0] d_rdata,
    output logic         d_ack,
    // shared memory port
    output logic         m_cyc,
    output logic         m_stb,
    output logic         m_we,
    output logic [15:0]  m_addr,
    output logic [127:0] m_wdata,
    output logic [15:0]  m_sel,
    input  logic [127:0] m_rdata,
    input  logic         m_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t state_r;
    state_t state_s;
    logic   last_grant_r;
    logic   last_grant_s;
    logic   i_req_s;
    logic   d_req_s;
    logic   i_ack_s;
    logic   d_ack_s;

    // Pick the next owner from the current requests and the most recent winner.
    function automatic state_t arbitrate(input logic i_req, input logic d_req, input logic last);
        state_t st;
        if (i_req && d_req) begin
            if (ROUND_ROBIN != 0) begin
                st = (last == PORT_I) ? GRANT_D : GRANT_I;
            end else begin
                st = GRANT_D;
            end
        end else if (i_req) begin
            st = GRANT_I;
        end else if (d_req) begin
            st = GRANT_D;
        end else begin
            st = IDLE;
        end
        return st;
    endfunction

    assign i_req_s = i_cyc & i_stb;
    assign d_req_s = d_cyc & d_stb;

    // Read data is broadcast; each requester qualifies it with its own ack.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // State and last-winner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= PORT_I;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Next-state logic: a completed transfer re-arbitrates immediately so
    // back-to-back grants need no idle bubble; dropping cyc aborts silently.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        i_ack_s      = 1'b0;
        d_ack_s      = 1'b0;
        case (state_r)
            IDLE: begin
                state_s = arbitrate(i_req_s, d_req_s, last_grant_r);
            end
            GRANT_I: begin
                if (!i_cyc) begin
                    state_s = IDLE;
                end else if (m_ack) begin
                    i_ack_s      = 1'b1;
                    last_grant_s = PORT_I;
                    state_s      = arbitrate(i_req_s, d_req_s, PORT_I);
                end else begin
                    state_s = GRANT_I;
                end
            end
            GRANT_D: begin
                if (!d_cyc) begin
                    state_s = IDLE;
                end else if (m_ack) begin
                    d_ack_s      = 1'b1;
                    last_grant_s = PORT_D;
                    state_s      = arbitrate(i_req_s, d_req_s, PORT_D);
                end else begin
                    state_s = GRANT_D;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bus steering from the granted port; reset forces idle values and drops any ack.
    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_addr  = 16'h0000;
        m_wdata = 128'h0;
        m_sel   = 16'h0000;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        if (reset) begin
            m_cyc = 1'b0;
            i_ack = 1'b0;
            d_ack = 1'b0;
        end else begin
            case (state_r)
                GRANT_I: begin
                    m_cyc   = 1'b1;
                    m_stb   = 1'b1;
                    m_we    = 1'b0;
                    m_addr  = i_addr;
                    m_wdata = 128'h0;
                    m_sel   = 16'hFFFF;
                    i_ack   = i_ack_s;
                end
                GRANT_D: begin
                    m_cyc   = 1'b1;
                    m_stb   = 1'b1;
                    m_we    = d_we;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                    m_sel   = d_sel;
                    d_ack   = d_ack_s;
                end
                default: begin
                    m_cyc = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses ROUND_ROBIN=1, instance 1 ROUND_ROBIN=0.
module tb_mem_arbiter;

    localparam int   N      = 2;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam logic [127:0] WD1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1357_9BDF;
    localparam logic [127:0] WD2 = 128'h0F0F_0F0F_F0F0_F0F0_AAAA_5555_1234_5678;
    localparam logic [127:0] WD3 = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;

    typedef struct {
        int           inst;
        logic         port;
        logic [15:0]  addr;
        logic         we;
        logic [15:0]  sel;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic         i_cyc [N];
    logic         i_stb [N];
    logic [15:0]  i_addr [N];
    logic [127:0] i_rdata [N];
    logic         i_ack [N];
    logic         d_cyc [N];
    logic         d_stb [N];
    logic         d_we [N];
    logic [15:0]  d_addr [N];
    logic [127:0] d_wdata [N];
    logic [15:0]  d_sel [N];
    logic [127:0] d_rdata [N];
    logic         d_ack [N];
    logic         m_cyc [N];
    logic         m_stb [N];
    logic         m_we [N];
    logic [15:0]  m_addr [N];
    logic [127:0] m_wdata [N];
    logic [15:0]  m_sel [N];
    logic [127:0] m_rdata [N];
    logic         m_ack [N];

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_arbiter #(.ROUND_ROBIN((g == 0) ? 1 : 0)) u_dut (
            .clk(clk),           .reset(reset),
            .i_cyc(i_cyc[g]),    .i_stb(i_stb[g]),     .i_addr(i_addr[g]),
            .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
            .d_cyc(d_cyc[g]),    .d_stb(d_stb[g]),     .d_we(d_we[g]),
            .d_addr(d_addr[g]),  .d_wdata(d_wdata[g]), .d_sel(d_sel[g]),
            .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
            .m_cyc(m_cyc[g]),    .m_stb(m_stb[g]),     .m_we(m_we[g]),
            .m_addr(m_addr[g]),  .m_wdata(m_wdata[g]), .m_sel(m_sel[g]),
            .m_rdata(m_rdata[g]), .m_ack(m_ack[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int k, input string name);
        n_checks++;
        if ({m_cyc[k], m_stb[k], m_we[k], i_ack[k], d_ack[k]} !== 5'b00000 ||
            m_addr[k] !== 16'h0000 || m_sel[k] !== 16'h0000 || m_wdata[k] !== 128'h0) begin
            n_errors++;
            $display("FAIL %s: got cyc/stb/we/iack/dack=%b%b%b%b%b addr=%h sel=%h wdata=%h, required all zero",
                     name, m_cyc[k], m_stb[k], m_we[k], i_ack[k], d_ack[k], m_addr[k], m_sel[k], m_wdata[k]);
        end
    endtask

    task automatic set_i(input int k, input logic on, input logic [15:0] addr);
        i_cyc[k]  = on;
        i_stb[k]  = on;
        i_addr[k] = addr;
    endtask

    task automatic set_d(input int k, input logic on, input logic we, input logic [15:0] addr,
                         input logic [15:0] sel, input logic [127:0] wdata);
        d_cyc[k]   = on;
        d_stb[k]   = on;
        d_we[k]    = we;
        d_addr[k]  = addr;
        d_sel[k]   = sel;
        d_wdata[k] = wdata;
    endtask

    function automatic exp_t mk_i(input int k, input logic [15:0] addr, input logic [127:0] rdata);
        exp_t e;
        e.inst = k; e.port = PORT_I; e.addr = addr; e.we = 1'b0;
        e.sel = 16'hFFFF; e.wdata = 128'h0; e.rdata = rdata;
        return e;
    endfunction

    function automatic exp_t mk_d(input int k, input logic [15:0] addr, input logic [15:0] sel,
                                  input logic [127:0] wdata, input logic [127:0] rdata);
        exp_t e;
        e.inst = k; e.port = PORT_D; e.addr = addr; e.we = 1'b1;
        e.sel = sel; e.wdata = wdata; e.rdata = rdata;
        return e;
    endfunction

    // Present an ack this cycle and record the transfer it should complete.
    task automatic ack_now(input int k, input exp_t e);
        sb_q.push_back(e);
        m_rdata[k] = e.rdata;
        m_ack[k]   = 1'b1;
    endtask

    task automatic wait_grant(input int k, input logic [15:0] addr, input string name);
        bit found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            #1;
            if (m_cyc[k] === 1'b1 && m_addr[k] === addr) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL %s: no grant of addr %h within 20 cycles, required a grant", name, addr);
        end
    endtask

    task automatic monitor();
        exp_t         e;
        logic [127:0] act_rd;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (i_ack[k] === 1'b1 || d_ack[k] === 1'b1) begin
                    n_checks++;
                    if (i_ack[k] === 1'b1 && d_ack[k] === 1'b1) begin
                        n_errors++;
                        $display("FAIL ack_onehot inst%0d: got i_ack=1 d_ack=1, required at most one", k);
                    end else if (sb_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_ack inst%0d: got i_ack=%b d_ack=%b, required no ack",
                                 k, i_ack[k], d_ack[k]);
                    end else begin
                        e      = sb_q.pop_front();
                        act_rd = d_ack[k] ? d_rdata[k] : i_rdata[k];
                        if (e.inst != k || e.port !== d_ack[k]) begin
                            n_errors++;
                            $display("FAIL grant_order: got inst%0d port %s, required inst%0d port %s",
                                     k, d_ack[k] ? "D" : "I", e.inst, e.port ? "D" : "I");
                        end
                        n_checks++;
                        if (m_addr[k] !== e.addr || m_we[k] !== e.we || m_sel[k] !== e.sel ||
                            m_wdata[k] !== e.wdata || act_rd !== e.rdata) begin
                            n_errors++;
                            $display("FAIL payload inst%0d: got addr=%h we=%b sel=%h wdata=%h rdata=%h, required addr=%h we=%b sel=%h wdata=%h rdata=%h",
                                     k, m_addr[k], m_we[k], m_sel[k], m_wdata[k], act_rd,
                                     e.addr, e.we, e.sel, e.wdata, e.rdata);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pat_rr [4];
        pat_rr = '{1, 0, 1, 0};   // expected D,I,D,I after the previous I winner
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            set_i(k, 1'b0, 16'h0000);
            set_d(k, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
            m_ack[k]   = 1'b0;
            m_rdata[k] = 128'h0;
        end
        fork
            monitor();
        join_none

        // Reset values, during and right after reset.
        repeat (3) tick();
        #1;
        check_idle(0, "reset_idle_rr1");
        check_idle(1, "reset_idle_rr0");
        tick(); reset = 1'b0;
        tick(); #1;
        check_idle(0, "post_reset_idle");

        // Instruction-only read, ack three cycles after grant.
        tick(); set_i(0, 1'b1, 16'h0040);
        #1; check1("i_no_grant_same_cycle", m_cyc[0], 1'b0);
        tick(); #1;
        check1("i_grant_cyc", m_cyc[0], 1'b1);
        check16("i_grant_addr", m_addr[0], 16'h0040);
        check1("i_grant_we", m_we[0], 1'b0);
        check16("i_grant_sel", m_sel[0], 16'hFFFF);
        repeat (2) tick();
        tick(); ack_now(0, mk_i(0, 16'h0040, 128'h1111_2222_3333_4444_5555_6666_7777_8888));
        tick(); m_ack[0] = 1'b0; set_i(0, 1'b0, 16'h0000);
        repeat (3) tick();
        #1; check1("i_release_idle", m_cyc[0], 1'b0);

        // Tie straight after reset: D first, then I with no idle cycle.
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        tick(); set_i(0, 1'b1, 16'h0080); set_d(0, 1'b1, 1'b1, 16'h1000, 16'h0003, WD1);
        tick(); #1;
        check16("tie_first_d_addr", m_addr[0], 16'h1000);
        check1("tie_first_d_we", m_we[0], 1'b1);
        check16("tie_first_d_sel", m_sel[0], 16'h0003);
        ack_now(0, mk_d(0, 16'h1000, 16'h0003, WD1, 128'hA0));
        tick(); m_ack[0] = 1'b0; set_d(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
        #1;
        check1("b2b_no_bubble", m_cyc[0], 1'b1);
        check16("b2b_i_addr", m_addr[0], 16'h0080);
        ack_now(0, mk_i(0, 16'h0080, 128'hA1));
        tick(); m_ack[0] = 1'b0; set_i(0, 1'b0, 16'h0000);
        repeat (3) tick();

        // Continuous requests on both ports, round-robin: D,I,D,I.
        set_i(0, 1'b1, 16'h0040); set_d(0, 1'b1, 1'b1, 16'h1000, 16'h0003, WD1);
        tick();
        for (int n = 0; n < 4; n++) begin
            if (pat_rr[n] == 1) ack_now(0, mk_d(0, 16'h1000, 16'h0003, WD1, 128'hB0 + 128'(n)));
            else                ack_now(0, mk_i(0, 16'h0040, 128'hB0 + 128'(n)));
            tick();
        end
        m_ack[0] = 1'b0;
        set_i(0, 1'b0, 16'h0000); set_d(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
        repeat (3) tick();

        // Make D the last winner, then abort an I grant and ack into IDLE.
        set_d(0, 1'b1, 1'b1, 16'h1100, 16'h00F0, WD2);
        wait_grant(0, 16'h1100, "d_single_grant");
        ack_now(0, mk_d(0, 16'h1100, 16'h00F0, WD2, 128'hC0));
        tick(); m_ack[0] = 1'b0; set_d(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
        repeat (3) tick();
        set_i(0, 1'b1, 16'h0200);
        tick(); #1;
        check1("abort_i_granted", m_cyc[0], 1'b1);
        set_i(0, 1'b0, 16'h0000);
        tick(); #1;
        check1("abort_to_idle", m_cyc[0], 1'b0);
        m_ack[0] = 1'b1;
        tick(); tick(); #1;
        check1("idle_ack_ignored", m_cyc[0], 1'b0);
        m_ack[0] = 1'b0;

        // Abort must not have moved last_grant off D, so this tie goes to I.
        tick(); set_i(0, 1'b1, 16'h0300); set_d(0, 1'b1, 1'b1, 16'h1000, 16'h0003, WD1);
        tick(); #1;
        check16("tie_after_abort_i", m_addr[0], 16'h0300);
        ack_now(0, mk_i(0, 16'h0300, 128'hC1));
        tick(); ack_now(0, mk_d(0, 16'h1000, 16'h0003, WD1, 128'hC2));
        tick(); m_ack[0] = 1'b0;
        set_i(0, 1'b0, 16'h0000); set_d(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
        repeat (3) tick();

        // Reset in GRANT_D with a coincident m_ack (last winner was D).
        set_d(0, 1'b1, 1'b1, 16'h1200, 16'h000F, WD3);
        tick(); #1;
        check16("rst_grant_d_addr", m_addr[0], 16'h1200);
        reset = 1'b1; m_ack[0] = 1'b1;
        #1;
        check1("rst_ack_dropped", d_ack[0], 1'b0);
        check_idle(0, "idle_during_reset");
        tick(); reset = 1'b0; m_ack[0] = 1'b0; set_d(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
        #1; check1("rst_m_cyc_low", m_cyc[0], 1'b0);
        tick(); set_i(0, 1'b1, 16'h0040); set_d(0, 1'b1, 1'b1, 16'h1000, 16'h0003, WD1);
        tick(); #1;
        check16("tie_after_reset_d", m_addr[0], 16'h1000);
        ack_now(0, mk_d(0, 16'h1000, 16'h0003, WD1, 128'hD0));
        tick(); m_ack[0] = 1'b0;
        set_i(0, 1'b0, 16'h0000); set_d(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
        repeat (3) tick();

        // Fixed priority instance: D keeps winning while it holds, then I.
        set_i(1, 1'b1, 16'h0040); set_d(1, 1'b1, 1'b1, 16'h1000, 16'h0003, WD1);
        tick();
        for (int n = 0; n < 4; n++) begin
            ack_now(1, mk_d(1, 16'h1000, 16'h0003, WD1, 128'hE0 + 128'(n)));
            tick();
        end
        m_ack[1] = 1'b0; set_d(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
        wait_grant(1, 16'h0040, "fp_i_after_d");
        ack_now(1, mk_i(1, 16'h0040, 128'hE9));
        tick(); m_ack[1] = 1'b0; set_i(1, 1'b0, 16'h0000);
        repeat (4) tick();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d transfers never acked, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
